reg_bank: RTL and testbench

- 32 x 32-bit general-purpose register bank for the multicycle MIPS datapath.
- Sits directly downstream of the destination-register selector: the write index is that selector's 5-bit output.
- Supplies two read ports and latches them into the A and B operand registers, which feed the ALU input muxes on the next cycle.
- Register 0 is hardwired to zero. The stack pointer comes out of reset at a fixed top-of-stack value.

---
 rtl/reg_bank.sv | 81 ++++++++
 tb/tb_reg_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank
// Description : 32 x 32-bit MIPS register file with A/B operand latches.
//               Optional macro REG_BANK_BYPASS_EN forwards same-edge write
//               data into the A/B latches.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = 32'd227,
    parameter int          RA_INDEX = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic        loadAB,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] AOut,
    output logic [31:0] BOut,
    output logic [31:0] SPOut
);

    localparam logic [4:0] c_sp_idx = SP_INDEX[4:0];

    logic [31:0] r_regs [32];
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] w_a_next;
    logic [31:0] w_b_next;
    logic        w_wr_en;
    logic        w_unused_ra;

    // The return-address index is a bookkeeping parameter only.
    assign w_unused_ra = (RA_INDEX != 0);

    assign w_wr_en = RegWrite && (WriteReg != 5'd0);

    assign ReadData1 = (ReadReg1 == 5'd0) ? 32'd0 : r_regs[ReadReg1];
    assign ReadData2 = (ReadReg2 == 5'd0) ? 32'd0 : r_regs[ReadReg2];
    assign SPOut     = r_regs[c_sp_idx];

`ifdef REG_BANK_BYPASS_EN
    // Forward write data so back-to-back write-back/operand-fetch sees it.
    assign w_a_next = (w_wr_en && (WriteReg == ReadReg1)) ? WriteData : ReadData1;
    assign w_b_next = (w_wr_en && (WriteReg == ReadReg2)) ? WriteData : ReadData2;
`else
    assign w_a_next = ReadData1;
    assign w_b_next = ReadData2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
            end
        end else if (w_wr_en) begin
            r_regs[WriteReg] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a <= 32'd0;
            r_b <= 32'd0;
        end else if (loadAB) begin
            r_a <= w_a_next;
            r_b <= w_b_next;
        end
    end

    assign AOut = r_a;
    assign BOut = r_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank
// Description : Directed self-checking bench for reg_bank (either build of
//               REG_BANK_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        loadAB;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] AOut;
    logic [31:0] BOut;
    logic [31:0] SPOut;

    int n_checks;
    int n_fail;

    reg_bank #(
        .SP_INDEX (29),
        .SP_RESET (32'd227),
        .RA_INDEX (31)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .loadAB    (loadAB),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .AOut      (AOut),
        .BOut      (BOut),
        .SPOut     (SPOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        RegWrite  = 1'b1;
        WriteReg  = idx;
        WriteData = data;
        tick();
        RegWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        ReadReg1 = idx;
        ReadReg2 = idx;
        #1;
        check_eq({tag, "_p1"}, ReadData1, exp);
        check_eq({tag, "_p2"}, ReadData2, exp);
    endtask

    logic [31:0] exp_a_sp;
    logic [31:0] exp_b_fwd;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'd0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        loadAB    = 1'b0;
`ifdef REG_BANK_BYPASS_EN
        exp_a_sp  = 32'd223;
        exp_b_fwd = 32'd9;
`else
        exp_a_sp  = 32'd227;
        exp_b_fwd = 32'd7;
`endif

        // Reset state, released mid-cycle
        tick();
        tick();
        #3 reset = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rd_check($sformatf("rst_r%0d", i), 5'(i), (i == 29) ? 32'd227 : 32'd0);
        end
        check_eq("rst_sp", SPOut, 32'd227);
        check_eq("rst_a", AOut, 32'd0);
        check_eq("rst_b", BOut, 32'd0);

        // Basic write/read with one-cycle latency
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd9;
        RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
        #1 check_eq("wr8_pre", ReadData1, 32'd0);
        tick();
        RegWrite = 1'b0;
        check_eq("wr8_post", ReadData1, 32'hDEADBEEF);
        check_eq("r9_zero", ReadData2, 32'd0);

        // Writes to register 0 are discarded
        wr(5'd0, 32'hFFFFFFFF);
        rd_check("r0_zero", 5'd0, 32'd0);
        rd_check("r8_kept", 5'd8, 32'hDEADBEEF);
        rd_check("r1_kept", 5'd1, 32'd0);

        // A/B latch and hold
        wr(5'd4, 32'd5);
        wr(5'd5, 32'd7);
        ReadReg1 = 5'd4; ReadReg2 = 5'd5; loadAB = 1'b1;
        tick();
        loadAB = 1'b0;
        check_eq("ab_a", AOut, 32'd5);
        check_eq("ab_b", BOut, 32'd7);
        ReadReg1 = 5'd8; ReadReg2 = 5'd0;
        tick();
        check_eq("hold_a", AOut, 32'd5);
        check_eq("hold_b", BOut, 32'd7);

        // Write and load on different indices in the same edge
        ReadReg1 = 5'd8; ReadReg2 = 5'd4; loadAB = 1'b1;
        wr(5'd12, 32'h0000ABCD);
        loadAB = 1'b0;
        check_eq("ind_a", AOut, 32'hDEADBEEF);
        check_eq("ind_b", BOut, 32'd5);
        rd_check("ind_r12", 5'd12, 32'h0000ABCD);

        // Stack pointer write coinciding with operand fetch of port 1
        ReadReg1 = 5'd29; ReadReg2 = 5'd4; loadAB = 1'b1;
        wr(5'd29, 32'd223);
        loadAB = 1'b0;
        check_eq("sp_new", SPOut, 32'd223);
        check_eq("sp_a", AOut, exp_a_sp);
        check_eq("sp_b", BOut, 32'd5);
        rd_check("sp_rd", 5'd29, 32'd223);

        // Same-edge write/fetch on port 2
        ReadReg1 = 5'd4; ReadReg2 = 5'd5; loadAB = 1'b1;
        wr(5'd5, 32'd9);
        loadAB = 1'b0;
        check_eq("fwd2_a", AOut, 32'd5);
        check_eq("fwd2_b", BOut, exp_b_fwd);

        // Reset mid-operation, including an in-flight write and load
        wr(5'd31, 32'h00400010);
        wr(5'd6, 32'h00000012);
        ReadReg1 = 5'd6; ReadReg2 = 5'd31; loadAB = 1'b1;
        tick();
        loadAB = 1'b0;
        check_eq("pre_a", AOut, 32'h00000012);
        check_eq("pre_b", BOut, 32'h00400010);
        #2 reset = 1'b0;
        #1;
        check_eq("mr_a", AOut, 32'd0);
        check_eq("mr_b", BOut, 32'd0);
        check_eq("mr_sp", SPOut, 32'd227);
        rd_check("mr_r31", 5'd31, 32'd0);
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h77777777;
        ReadReg1 = 5'd8; loadAB = 1'b1;
        tick();
        RegWrite = 1'b0; loadAB = 1'b0;
        rd_check("mr_r7", 5'd7, 32'd0);
        rd_check("mr_r8", 5'd8, 32'd0);
        check_eq("mr_a2", AOut, 32'd0);
        #3 reset = 1'b1;
        tick();
        wr(5'd31, 32'h00000055);
        rd_check("post_r31", 5'd31, 32'h00000055);
        check_eq("post_sp", SPOut, 32'd227);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
